// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared arithmetic definitions for the serial adder datapath: the FSM
//   state encoding and the default operand width. Any block that sequences
//   a bit-serial operation imports this package.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Request/response bundle between a controller and serial_adder.
//   master : controller side, drives start, a, b, cin, sub.
//   slave  : adder side, drives busy, done, sum, cout, ovf.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder_fa.sv
// full_adder_cell
//   One-bit full adder assembled from two half-adder stages and an OR that
//   merges their carries. Purely combinational; meant to be shared by the
//   serial adder and any future parallel adder.
//   Ports: a, b, ci (inputs) -> s (sum bit), co (carry out).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;   // first half adder: a + b
    logic c1;
    logic c2;   // second half adder: s1 + ci

    assign s1 = a ^ b;
    assign c1 = a & b;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. Operands are consumed LSB first through a
//   single full_adder_cell and a carry flop, one bit per clock, so a
//   WIDTH-bit operation takes WIDTH busy cycles plus one done cycle.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, overrides everything
//     bus  - serial_adder_if.slave: start/a/b/cin/sub in,
//            busy/done/sum/cout/ovf out (all outputs registered)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cout_r;
    logic             ovf_r;

    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic             load;

    full_adder_cell u_fa (
        .a  (ra[0]),
        .b  (rb[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // A request is only accepted when no operation is in flight; DONE also
    // accepts so back-to-back requests lose no cycle.
    assign load     = bus.start && (state == IDLE || state == DONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = BUSY;
            BUSY:    if (last_bit)  state_nx = DONE;
            DONE:    state_nx = bus.start ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            BUSY:    bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Result register fills from the top, so after WIDTH shifts bit 0 of
    // the operands has landed in bit 0 of the result.
    always_comb begin
        sum_nx            = sum_r >> 1;
        sum_nx[WIDTH-1]   = s_bit;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry.
            ra    <= bus.a;
            rb    <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            cnt   <= '0;
        end else if (state == BUSY) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            carry <= c_bit;
            sum_r <= sum_nx;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout_r <= c_bit;
                // On the MSB, 'carry' is the carry into the sign bit.
                ovf_r  <= carry ^ c_bit;
            end
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    typedef struct {
        longint sum;
        bit     cout;
        bit     ovf;
        int     gap;   // required cycles since previous done, 0 = don't care
    } exp_t;

    logic clk;
    logic rst;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(2)) if2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q2[$];
    int   done8 = 0, done2 = 0;
    int   cyc8 = 0, cyc2 = 0;
    int   last8 = 0, last2 = 0;
    int   busy8 = 0, busy2 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endfunction

    // Reference: plain integer arithmetic, unsigned for sum/cout and signed
    // range test for overflow.
    function automatic exp_t model(int w, longint a, longint b, bit cin, bit sub);
        exp_t   e;
        longint r, sa, sb, sr, half;
        half  = longint'(1) << (w - 1);
        r     = sub ? (a - b) : (a + b + cin);
        e.sum = r & ((longint'(1) << w) - 1);
        e.cout = sub ? (a >= b) : (r >= (longint'(1) << w));
        sa    = (a >= half) ? a - 2 * half : a;
        sb    = (b >= half) ? b - 2 * half : b;
        sr    = sub ? (sa - sb) : (sa + sb + cin);
        e.ovf = (sr > half - 1) || (sr < -half);
        e.gap = 0;
        return e;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        cyc8++;
        if (if8.done === 1'b1) begin
            chk("w8_busy_len", 64'(busy8), 64'd8);
            busy8 = 0;
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                chk("w8_sum",  64'(if8.sum),  64'(e.sum));
                chk("w8_cout", 64'(if8.cout), 64'(e.cout));
                chk("w8_ovf",  64'(if8.ovf),  64'(e.ovf));
                if (e.gap != 0) chk("w8_done_gap", 64'(cyc8 - last8), 64'(e.gap));
            end
            last8 = cyc8;
            done8++;
        end else if (if8.busy !== 1'b1) begin
            busy8 = 0;
        end
        if (if8.busy === 1'b1) busy8++;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc2++;
        if (if2.done === 1'b1) begin
            chk("w2_busy_len", 64'(busy2), 64'd2);
            busy2 = 0;
            if (q2.size() == 0) begin
                chk("w2_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                chk("w2_sum",  64'(if2.sum),  64'(e.sum));
                chk("w2_cout", 64'(if2.cout), 64'(e.cout));
                chk("w2_ovf",  64'(if2.ovf),  64'(e.ovf));
            end
            last2 = cyc2;
            done2++;
        end else if (if2.busy !== 1'b1) begin
            busy2 = 0;
        end
        if (if2.busy === 1'b1) busy2++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait8(int n);
        for (int i = 0; i < 40; i++) begin
            if (done8 > n) return;
            tick();
        end
        chk("w8_done_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait2(int n);
        for (int i = 0; i < 20; i++) begin
            if (done2 > n) return;
            tick();
        end
        chk("w2_done_timeout", 64'd1, 64'd0);
    endtask

    task automatic run8(logic [7:0] a, logic [7:0] b, bit cin, bit sub);
        int n;
        q8.push_back(model(8, a, b, cin, sub));
        n = done8;
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub;
        tick();
        if8.start = 1'b0;
        wait8(n);
    endtask

    task automatic run2(logic [1:0] a, logic [1:0] b, bit cin, bit sub);
        int n;
        q2.push_back(model(2, a, b, cin, sub));
        n = done2;
        if2.start = 1'b1; if2.a = a; if2.b = b; if2.cin = cin; if2.sub = sub;
        tick();
        if2.start = 1'b0;
        wait2(n);
    endtask

    task automatic chk_zero8(string nm);
        chk({nm, "_busy"}, 64'(if8.busy), 64'd0);
        chk({nm, "_done"}, 64'(if8.done), 64'd0);
        chk({nm, "_sum"},  64'(if8.sum),  64'd0);
        chk({nm, "_cout"}, 64'(if8.cout), 64'd0);
        chk({nm, "_ovf"},  64'(if8.ovf),  64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_t e1, e2;
        int   n;

        rst = 1'b1;
        if8.start = 1'b1; if8.a = 8'd9; if8.b = 8'd9; if8.cin = 1'b1; if8.sub = 1'b0;
        if2.start = 1'b1; if2.a = 2'd1; if2.b = 2'd1; if2.cin = 1'b0; if2.sub = 1'b0;
        tick();
        tick();
        chk_zero8("rst");
        chk("rst_w2_busy", 64'(if2.busy), 64'd0);
        chk("rst_w2_sum",  64'(if2.sum),  64'd0);
        rst = 1'b0;
        if8.start = 1'b0;
        if2.start = 1'b0;
        tick();
        chk("idle_after_rst_busy", 64'(if8.busy), 64'd0);

        // directed arithmetic
        run8(8'd200, 8'd100, 1'b0, 1'b0);
        run8(8'd5,   8'd7,   1'b1, 1'b1);
        run8(8'd7,   8'd5,   1'b0, 1'b1);

        // overflow, then back-to-back with start held through BUSY and DONE
        e1 = model(8, 8'h7F, 8'h01, 1'b0, 1'b0);
        e2 = model(8, 8'd3, 8'd4, 1'b0, 1'b0);
        e2.gap = 9;
        q8.push_back(e1);
        q8.push_back(e2);
        n = done8;
        if8.start = 1'b1; if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; if8.sub = 1'b0;
        tick();
        if8.a = 8'd3; if8.b = 8'd4;
        wait8(n);
        tick();
        if8.start = 1'b0;
        wait8(n + 1);
        tick();

        // start pulsed in busy cycle 3 must be ignored
        q8.push_back(model(8, 8'd17, 8'd33, 1'b1, 1'b0));
        n = done8;
        if8.start = 1'b1; if8.a = 8'd17; if8.b = 8'd33; if8.cin = 1'b1; if8.sub = 1'b0;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        if8.start = 1'b1; if8.a = 8'd250; if8.b = 8'd1; if8.sub = 1'b1;
        tick();
        if8.start = 1'b0;
        wait8(n);
        tick();

        // reset in busy cycle 4 aborts the operation
        n = done8;
        if8.start = 1'b1; if8.a = 8'd99; if8.b = 8'd77; if8.cin = 1'b0; if8.sub = 1'b0;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_zero8("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_idle_busy", 64'(if8.busy), 64'd0);
        chk("midrst_no_done", 64'(done8), 64'(n));
        run8(8'd12, 8'd30, 1'b1, 1'b0);

        // exhaustive WIDTH=2
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++)
                        run2(2'(a), 2'(b), c[0], s[0]);

        // random WIDTH=8
        for (int i = 0; i < 150; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        tick();
        tick();
        chk("w8_queue_drained", 64'(q8.size()), 64'd0);
        chk("w2_queue_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. Adds two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. Trades latency for area against a parallel ripple adder. Sits in the arithmetic datapath as the sequential successor of the single-bit half-adder cell, with a start/busy/done handshake toward its controller.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add, sampled with start.
- sub  input  1  0 computes a+b+cin; 1 computes a-b (a + ~b + 1, cin ignored). Sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; for sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: on start=1:
  - load a into shift register ra.
  - load (sub ? ~b : b) into shift register rb.
  - load carry = (sub ? 1 : cin); clear the bit counter; go to BUSY.
- BUSY, each cycle:
  - s = ra[0]^rb[0]^carry; carry <= majority(ra[0], rb[0], carry).
  - Shift ra and rb right by one; shift s into the MSB of the result register.
  - Increment the counter.
  - On the cycle the counter reaches WIDTH-1: go to DONE, latch cout <= the new carry and ovf <= carry_in_to_MSB ^ carry_out_of_MSB.
- DONE: done=1 for exactly one cycle.
  - With start=1: reload and go to BUSY (back-to-back accepted).
  - Otherwise go to IDLE.
- start while BUSY: ignored; operands are not re-sampled.
- Counter width: $clog2(WIDTH+1). WIDTH=1 gives one BUSY cycle, with ovf computed on bit 0.
- Result arithmetic is modulo 2^WIDTH; cout carries the bit 2^WIDTH.

## Timing

- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. The shift registers and counter are also cleared.
- rst=1 overrides every other input in any state, including mid-BUSY. The in-flight operation is discarded and the next cycle is IDLE with all outputs at reset values.
- Latency: start sampled at edge E0, then busy=1 from E0 through E(WIDTH).
- done=1 and busy=0 in the cycle after edge E(WIDTH); sum, cout and ovf are valid from that same cycle.
- Throughput: one operation per WIDTH+1 cycles when start is held high continuously.
- sum, cout and ovf change only in BUSY or on reset. Between operations they hold the last result; intermediate partial sums are visible on sum while busy=1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- A shared arithmetic package holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - the default WIDTH.
- Sub-module full_adder_cell (a, b, ci → s, co) is built from two half-adder equations plus OR. It is instantiated once inside serial_adder and is reusable by future parallel adders.
- The FSM, counter and shift registers stay in serial_adder.

## Test plan

Bench uses WIDTH=8 unless stated.
- Reset: hold rst=1 for 2 cycles with start=1 → busy=0, done=0, sum=0, cout=0, ovf=0; no operation is started.
- Add: a=200, b=100, cin=0, sub=0, start pulse → busy for exactly 8 cycles, then a done pulse with sum=8'd44, cout=1, ovf=0.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) → sum=8'hFE, cout=0, ovf=0. Also a=7, b=5 → sum=8'h02, cout=1.
- Overflow: a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1. Back-to-back start held in the DONE cycle with a=3, b=4 → second done pulse exactly 9 cycles after the first, sum=7.
- Interference: pulse start again in BUSY cycle 3 with different operands → ignored, result unchanged. Assert rst in BUSY cycle 4 → next cycle all outputs are 0 in IDLE; a fresh operation after that completes correctly.
- Exhaustive, WIDTH=2: all a, b, cin, sub combinations checked against a reference model (a+b+cin or a-b), with busy lasting exactly 2 cycles each time.
